i2s_rx_capture: RTL
===================

# i2s_rx_capture

Downstream capture stage for the PIO I2S transmitter. It oversamples the serial pins the PIO drives (SDATA, BCLK, LRCLK) on clk_25mhz and reconstructs each stereo frame into parallel left/right words. Frames are handed off through a one-entry valid/ready output register. The block gives the on-chip loopback bench and logic-analyser hooks a checked view of what the PIO actually shifted out, and flags framing errors and overruns.

## Interface
- WIDTH, 16: bits per channel word; legal range 2..32.
- clk_25mhz  in  1  system clock
- reset  in  1  synchronous, active-high
- enable  in  1  capture enable; low forces idle and clears lock
- sdata  in  1  serial data pin (asynchronous)
- bclk  in  1  bit clock pin (asynchronous)
- lrclk  in  1  word select pin (asynchronous); 0 = left, 1 = right
- out_ready  in  1  consumer accepts the frame held on outputs
- clr_err  in  1  one-cycle pulse; clears the sticky flags
- left_out  out  WIDTH  captured left word
- right_out  out  WIDTH  captured right word
- out_valid  out  1  frame held on outputs is valid
- frame_err  out  1  sticky: a word had a bit count other than WIDTH
- overrun  out  1  sticky: a frame completed while the output register was full
- frame_cnt  out  16  count of frames loaded into the output register; wraps

## Operation
- sdata, bclk and lrclk each pass through a 2-FF synchronizer. A registered copy of synchronized bclk provides edge detection. Only the BCLK rising edge (rise) is acted on.
- On each rise:
  - shreg <= {shreg[WIDTH-2:0], sdata}.
  - bitcnt increments and saturates at WIDTH+1.
  - lr_s is captured into lr_prev.
- Word end: a rise where sampled lrclk != lr_prev. I2S one-bit delay means the bit sampled on this rise is the LSB of the finishing word.
  - word = shift result including this bit.
  - The word is good if bitcnt+1 == WIDTH.
  - After a word end, bitcnt restarts at 0.
- Lock FSM states:
  - UNLOCKED: rises shift normally, and the first word end moves the FSM to LOCKED. That first word is discarded because it is partial.
  - LOCKED: words are processed.
  - enable low or reset returns the FSM to UNLOCKED and clears shreg, bitcnt and the left-good flag.
- Word handling while LOCKED:
  - Finished word with lr_prev=0 (left): stored into left_hold; left_good = good.
  - Finished word with lr_prev=1 (right): completes the frame. The frame is emitted only if left_good and the right word is good.
  - Any bad word sets frame_err and drops the frame.
- Emit, by state of the output register:
  - Output register empty, or out_valid && out_ready in the same cycle: load left_out/right_out, out_valid=1, frame_cnt+1.
  - out_valid && !out_ready: set overrun, drop the new frame, keep the held frame unchanged.
- out_valid && out_ready with no new frame: out_valid <= 0. Data outputs keep their last value.
- clr_err clears frame_err and overrun. If a new error occurs in the same cycle, the flag ends set.
- WIDTH arithmetic: bitcnt is $clog2(WIDTH+2) bits. Words longer than WIDTH keep only the last WIDTH bits and are flagged as errors.

## Timing
- Reset values: left_out=0, right_out=0, out_valid=0, frame_err=0, overrun=0, frame_cnt=0, FSM=UNLOCKED.
- Pin to rise: a BCLK pin edge is acted on in the 3rd clk_25mhz cycle after it is registered (2 sync + 1 edge).
- out_valid rises 1 cycle after the rise that samples the right LSB, i.e. 4 cycles after the BCLK pin edge.
- Input constraint: BCLK high and low phases are each ≥3 clk cycles (BCLK ≤ 4.1 MHz). SDATA and LRCLK are stable from the falling edge to the next rising edge.
- out_ready is sampled every cycle; a transfer happens in any cycle where out_valid && out_ready.
- enable deasserted mid-word: takes effect the next cycle, with no partial frame emitted. The output register and flags are unaffected.

## Test plan
- Reset: after reset, all outputs read 0. Toggling bclk with lrclk constant produces no out_valid and frame_err=0.
- Basic: send frames L=0x1234 R=0xABCD at BCLK period 8 with out_ready=1.
  - The first partial frame is discarded.
  - The next frame gives left_out=0x1234, right_out=0xABCD, one-cycle out_valid, frame_cnt=1.
- Backpressure: out_ready=0, send two frames (0x1111/0x2222, then 0x3333/0x4444).
  - Outputs hold 0x1111/0x2222, overrun=1, frame_cnt=1.
  - clr_err then clears overrun.
- Bad framing: a left word of 15 bits gives frame_err=1 and no out_valid for that frame. The following good frame 0x5A5A/0xA5A5 is emitted.
- Simultaneous: out_valid=1 held, out_ready=1 in the exact cycle a new frame 0x0F0F/0xF0F0 completes.
  - New data is loaded, out_valid stays 1, no overrun, frame_cnt increments.
- Reset/enable mid-frame: assert reset (then, separately, drop enable) at bit 7 of a left word.
  - FSM returns to UNLOCKED and the interrupted frame is not emitted.
  - The first complete frame after relock is emitted correctly.

Source files
------------

// File: rtl/i2s_rx_capture_if.sv
// i2s_rx_capture_if
//   Output stream of the I2S capture stage: one stereo frame per transfer.
//   A transfer happens on any clock edge where out_valid && out_ready.
//   Ports:
//     left_out  / right_out : captured channel words (WIDTH bits each)
//     out_valid             : frame on left_out/right_out is valid
//     out_ready             : consumer accepts the held frame
//   Modports: master = capture block (producer), slave = consumer.
interface i2s_rx_capture_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] left_out;
  logic [WIDTH-1:0] right_out;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output left_out,
    output right_out,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  left_out,
    input  right_out,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/i2s_rx_capture.sv
// i2s_rx_capture
//   Oversamples the I2S pins (sdata, bclk, lrclk) on clk_25mhz, rebuilds each
//   stereo frame into parallel words and hands it off through a one-entry
//   valid/ready output register. Flags framing errors and overruns.
//   Ports:
//     clk_25mhz, reset : system clock, synchronous active-high reset
//     enable           : capture enable; low forces idle and drops lock
//     sdata/bclk/lrclk : asynchronous serial pins (lrclk 0 = left, 1 = right)
//     clr_err          : one-cycle pulse clearing the sticky flags
//     out_if           : output frame stream (left_out, right_out, valid/ready)
//     frame_err        : sticky, a word had a bit count other than WIDTH
//     overrun          : sticky, a frame completed while the output was full
//     frame_cnt        : frames loaded into the output register (wraps)
module i2s_rx_capture #(
  parameter int WIDTH = 16
) (
  input  logic                clk_25mhz,
  input  logic                reset,
  input  logic                enable,
  input  logic                sdata,
  input  logic                bclk,
  input  logic                lrclk,
  input  logic                clr_err,
  i2s_rx_capture_if.master    out_if,
  output logic                frame_err,
  output logic                overrun,
  output logic [15:0]         frame_cnt
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {UNLOCKED, LOCKED} state_e;

  // Pin synchronizers, bit order {sdata, bclk, lrclk}. Not reset: they only
  // track the pins, and leaving them free-running avoids a false bclk edge
  // when reset releases while the bclk pin is high.
  logic [2:0] sync1_q, sync1_d;
  logic [2:0] sync2_q, sync2_d;
  logic       bclk_prev_q, bclk_prev_d;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    bitcnt_q, bitcnt_d;
  logic             lr_prev_q, lr_prev_d;
  logic [WIDTH-1:0] left_hold_q, left_hold_d;
  logic             left_good_q, left_good_d;
  logic [WIDTH-1:0] left_out_q, left_out_d;
  logic [WIDTH-1:0] right_out_q, right_out_d;
  logic             out_valid_q, out_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;

  logic             sd_s, bclk_s, lr_s;
  logic             rise, word_end, good;
  logic [WIDTH-1:0] shift_nx;
  logic             new_frame, new_err, ovr_set;

  assign sd_s   = sync2_q[2];
  assign bclk_s = sync2_q[1];
  assign lr_s   = sync2_q[0];

  always_comb begin
    sync1_d     = {sdata, bclk, lrclk};
    sync2_d     = sync1_q;
    bclk_prev_d = bclk_s;

    state_d     = state_q;
    shreg_d     = shreg_q;
    bitcnt_d    = bitcnt_q;
    lr_prev_d   = lr_prev_q;
    left_hold_d = left_hold_q;
    left_good_d = left_good_q;
    left_out_d  = left_out_q;
    right_out_d = right_out_q;
    out_valid_d = out_valid_q;
    frame_cnt_d = frame_cnt_q;

    rise      = bclk_s & ~bclk_prev_q;
    shift_nx  = {shreg_q[WIDTH-2:0], sd_s};
    // One-bit I2S delay: the rise that sees lrclk flip samples the LSB of
    // the word that is finishing.
    word_end  = rise && (lr_s != lr_prev_q);
    good      = (bitcnt_q == CNT_LAST);
    new_frame = 1'b0;
    new_err   = 1'b0;
    ovr_set   = 1'b0;

    if (!enable) begin
      state_d     = UNLOCKED;
      shreg_d     = '0;
      bitcnt_d    = '0;
      left_good_d = 1'b0;
    end else if (rise) begin
      shreg_d   = shift_nx;
      lr_prev_d = lr_s;
      if (word_end) begin
        bitcnt_d = '0;
        if (state_q == UNLOCKED) begin
          // First word end only establishes alignment; that word is partial.
          state_d = LOCKED;
        end else if (!lr_prev_q) begin
          left_hold_d = shift_nx;
          left_good_d = good;
          new_err     = !good;
        end else begin
          new_frame   = left_good_q && good;
          new_err     = !good;
          // A left word pairs with exactly one right word.
          left_good_d = 1'b0;
        end
      end else if (bitcnt_q != CNT_MAX) begin
        bitcnt_d = bitcnt_q + 1'b1;
      end
    end

    if (new_frame) begin
      if (!out_valid_q || out_if.out_ready) begin
        left_out_d  = left_hold_q;
        right_out_d = shift_nx;
        out_valid_d = 1'b1;
        frame_cnt_d = frame_cnt_q + 16'd1;
      end else begin
        ovr_set = 1'b1;
      end
    end else if (out_valid_q && out_if.out_ready) begin
      out_valid_d = 1'b0;
    end

    // A new error in the clearing cycle wins over the clear.
    frame_err_d = (frame_err_q & ~clr_err) | new_err;
    overrun_d   = (overrun_q & ~clr_err) | ovr_set;
  end

  always_ff @(posedge clk_25mhz) begin
    sync1_q     <= sync1_d;
    sync2_q     <= sync2_d;
    bclk_prev_q <= bclk_prev_d;
  end

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      state_q     <= UNLOCKED;
      shreg_q     <= '0;
      bitcnt_q    <= '0;
      lr_prev_q   <= 1'b0;
      left_hold_q <= '0;
      left_good_q <= 1'b0;
      left_out_q  <= '0;
      right_out_q <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bitcnt_q    <= bitcnt_d;
      lr_prev_q   <= lr_prev_d;
      left_hold_q <= left_hold_d;
      left_good_q <= left_good_d;
      left_out_q  <= left_out_d;
      right_out_q <= right_out_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign out_if.left_out  = left_out_q;
  assign out_if.right_out = right_out_q;
  assign out_if.out_valid = out_valid_q;
  assign frame_err        = frame_err_q;
  assign overrun          = overrun_q;
  assign frame_cnt        = frame_cnt_q;

endmodule
